// File: rtl/nano_intc.sv
// nano_intc: eight-source priority interrupt controller with in-service nesting,
// vector drive during the core's acknowledge cycle and a small I/O register file.

module nano_intc_src #(
  parameter bit LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic s1, s, s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
      pend <= 1'b0;
    end else begin
      s1  <= irq;
      s   <= s1;
      s_d <= s;
      // Level lines: the clear lands for one cycle, then a still-high line reasserts.
      if (LEVEL) begin
        if (clr)    pend <= 1'b0;
        else if (s) pend <= 1'b1;
      end else begin
        if (s & ~s_d) pend <= 1'b1;
        else if (clr) pend <= 1'b0;
      end
    end
  end
endmodule

module nano_intc #(
  parameter logic [3:0] DEV_MASK = 4'h8,
  parameter logic [3:0] DEV_PEND = 4'h9,
  parameter logic [3:0] DEV_EOI  = 4'hA,
  parameter logic [7:0] VEC_BASE = 8'h00,
  parameter logic [7:0] LEVEL    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  output logic       INT_REQ,
  input  logic       INT_ACK,
  input  logic [3:0] DS,
  input  logic       RW,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe
);
  localparam int NUM_SRC = 8;

  logic [NUM_SRC-1:0] mask, pend, isr, isr_nxt, act, clr;
  logic [2:0]         cand;
  logic [3:0]         cur;
  logic               act_any, ack_fire, wr_mask, wr_pend, wr_eoi;

  assign act      = pend & mask;
  assign act_any  = |act;
  assign ack_fire = INT_ACK & act_any;
  assign wr_mask  = RW && (DS == DEV_MASK);
  assign wr_pend  = RW && (DS == DEV_PEND);
  assign wr_eoi   = RW && (DS == DEV_EOI);

  // cand defaults to 7 so a spurious acknowledge still gets a defined vector.
  always_comb begin
    cand = 3'd7;
    cur  = 4'd8;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (act[i]) cand = i[2:0];
      if (isr[i]) cur  = i[3:0];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      assign clr[g] = (ack_fire && (cand == 3'(g))) || (wr_pend && D_in[g]);
      nano_intc_src #(.LEVEL(LEVEL[g])) u_src (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq[g]),
        .clr  (clr[g]),
        .pend (pend[g])
      );
    end
  endgenerate

  always_comb begin
    isr_nxt = isr;
    if (wr_eoi)   isr_nxt = isr & (isr - 8'd1);
    if (ack_fire) isr_nxt[cand] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '0;
      isr     <= '0;
      INT_REQ <= 1'b0;
    end else begin
      if (wr_mask) mask <= D_in;
      isr     <= isr_nxt;
      INT_REQ <= act_any && ({1'b0, cand} < cur);
    end
  end

  // Acknowledge drive takes the bus even if an I/O access coincides.
  always_comb begin
    D_oe  = 1'b0;
    D_out = 8'h00;
    if (!rst) begin
      if (INT_ACK) begin
        D_oe  = 1'b1;
        D_out = {VEC_BASE[7:5], cand, 2'b00};
      end else if (!RW) begin
        case (DS)
          DEV_MASK: begin D_oe = 1'b1; D_out = mask; end
          DEV_PEND: begin D_oe = 1'b1; D_out = pend; end
          DEV_EOI:  begin D_oe = 1'b1; D_out = isr;  end
          default:  ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nano_intc.sv
// Scenario bench for nano_intc: an edge-mode instance and a level-mode (source 0)
// instance share clock, reset and the I/O bus; expectations go through a queue.
module tb_nano_intc;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] irq = '0, irq1 = '0, D_in = '0;
  logic       INT_ACK = 1'b0, ack1 = 1'b0, RW = 1'b0;
  logic [3:0] DS = 4'hF;
  logic       INT_REQ, D_oe, req1, oe1;
  logic [7:0] D_out, dout1;

  typedef struct { string name; logic [7:0] val; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [7:0] v, v1;
  logic       oe;

  always #5 clk = ~clk;

  nano_intc u0 (.clk(clk), .rst(rst), .irq(irq), .INT_REQ(INT_REQ), .INT_ACK(INT_ACK),
                .DS(DS), .RW(RW), .D_in(D_in), .D_out(D_out), .D_oe(D_oe));
  nano_intc #(.LEVEL(8'h01)) u1 (.clk(clk), .rst(rst), .irq(irq1), .INT_REQ(req1), .INT_ACK(ack1),
                .DS(DS), .RW(RW), .D_in(D_in), .D_out(dout1), .D_oe(oe1));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] ds, output logic [7:0] r0, output logic oe0, output logic [7:0] r1);
    DS = ds; RW = 1'b0; #1;
    r0 = D_out; oe0 = D_oe; r1 = dout1;
    DS = 4'hF; #1;
  endtask

  task automatic wr(input logic [3:0] ds, input logic [7:0] d);
    DS = ds; RW = 1'b1; D_in = d;
    cyc(1);
    DS = 4'hF; RW = 1'b0; D_in = '0;
  endtask

  task automatic test_reset;
    exp_q.push_back('{"rst_int_req", 8'h00});
    exp_q.push_back('{"rst_d_oe", 8'h00});
    exp_q.push_back('{"rst_mask", 8'h00});
    exp_q.push_back('{"rst_pend", 8'h00});
    exp_q.push_back('{"rst_isr", 8'h00});
    cyc(3); rst = 1'b0; cyc(1);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, D_oe} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_oe, e.val); end
    rd(4'h8, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
  endtask

  task automatic test_edge;
    wr(4'h8, 8'hFF);
    irq[3] = 1'b1; exp_q.push_back('{"edge_pend", 8'h08}); exp_q.push_back('{"edge_req_early", 8'h00});
    cyc(1); irq[3] = 1'b0;
    cyc(2); rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    exp_q.push_back('{"edge_req", 8'h01});
    cyc(1);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    INT_ACK = 1'b1; exp_q.push_back('{"edge_vec", 8'h0C}); exp_q.push_back('{"edge_vec_oe", 8'h01}); #1;
    e = exp_q.pop_front(); checks++; if (D_out !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_out, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, D_oe} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_oe, e.val); end
    cyc(1); INT_ACK = 1'b0;
    exp_q.push_back('{"ack_pend", 8'h00}); exp_q.push_back('{"ack_isr", 8'h08}); exp_q.push_back('{"ack_req", 8'h00});
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    cyc(1);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
  endtask

  task automatic test_nest;
    irq[5] = 1'b1; exp_q.push_back('{"nest_low_req", 8'h00});
    cyc(4);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    irq[1] = 1'b1; exp_q.push_back('{"nest_high_req", 8'h01});
    cyc(4);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    INT_ACK = 1'b1; exp_q.push_back('{"nest_vec", 8'h04}); #1;
    e = exp_q.pop_front(); checks++; if (D_out !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_out, e.val); end
    cyc(1); INT_ACK = 1'b0;
    exp_q.push_back('{"nest_isr", 8'h0A});
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
  endtask

  task automatic test_eoi;
    wr(4'hA, 8'h5A); exp_q.push_back('{"eoi1_isr", 8'h08});
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    wr(4'hA, 8'h00); exp_q.push_back('{"eoi2_isr", 8'h00}); exp_q.push_back('{"eoi_req", 8'h01});
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    cyc(1);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    INT_ACK = 1'b1; exp_q.push_back('{"eoi_vec5", 8'h14}); #1;
    e = exp_q.pop_front(); checks++; if (D_out !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_out, e.val); end
    cyc(1); INT_ACK = 1'b0;
    wr(4'hA, 8'h00);
    irq[5] = 1'b0; irq[1] = 1'b0;
    cyc(2);
  endtask

  task automatic test_mask;
    wr(4'h8, 8'h00);
    irq[2] = 1'b1; exp_q.push_back('{"mask_pend", 8'h04}); exp_q.push_back('{"mask_req_off", 8'h00});
    cyc(4); rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    wr(4'h8, 8'h04); exp_q.push_back('{"mask_req_lag", 8'h00}); exp_q.push_back('{"mask_req_on", 8'h01});
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    cyc(1);
    e = exp_q.pop_front(); checks++; if ({7'b0, INT_REQ} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, INT_REQ, e.val); end
    exp_q.push_back('{"rd_pend", 8'h04}); exp_q.push_back('{"rd_pend_oe", 8'h01});
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, oe} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, oe, e.val); end
  endtask

  task automatic test_w1c_race;
    irq[2] = 1'b0;
    wr(4'h9, 8'h04); exp_q.push_back('{"w1c_pend", 8'h00});
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    cyc(3);
    irq[2] = 1'b1; cyc(2);
    wr(4'h9, 8'h04); exp_q.push_back('{"race_pend", 8'h04});
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    cyc(1);
    INT_ACK = 1'b1; exp_q.push_back('{"race_vec", 8'h08}); #1;
    e = exp_q.pop_front(); checks++; if (D_out !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_out, e.val); end
    cyc(1); INT_ACK = 1'b0;
    wr(4'hA, 8'h00);
    irq[2] = 1'b0;
    cyc(2);
  endtask

  task automatic test_spurious;
    INT_ACK = 1'b1; exp_q.push_back('{"spur_vec", 8'h1C}); exp_q.push_back('{"spur_isr", 8'h00}); exp_q.push_back('{"spur_pend", 8'h00});
    #1;
    e = exp_q.pop_front(); checks++; if (D_out !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, D_out, e.val); end
    cyc(1); INT_ACK = 1'b0;
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v, e.val); end
  endtask

  task automatic test_level_reset;
    wr(4'h8, 8'hFF);
    irq1[0] = 1'b1; exp_q.push_back('{"lvl_req", 8'h01});
    cyc(4);
    e = exp_q.pop_front(); checks++; if ({7'b0, req1} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, req1, e.val); end
    ack1 = 1'b1; exp_q.push_back('{"lvl_vec", 8'h00}); #1;
    e = exp_q.pop_front(); checks++; if (dout1 !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, dout1, e.val); end
    cyc(1); ack1 = 1'b0;
    exp_q.push_back('{"lvl_pend_clr", 8'h00}); exp_q.push_back('{"lvl_pend_re", 8'h01});
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v1 !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v1, e.val); end
    cyc(1); rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v1 !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v1, e.val); end
    ack1 = 1'b1; rst = 1'b1;
    exp_q.push_back('{"mid_rst_pend", 8'h00}); exp_q.push_back('{"mid_rst_isr", 8'h00});
    exp_q.push_back('{"mid_rst_req", 8'h00}); exp_q.push_back('{"mid_rst_oe", 8'h00});
    cyc(1); rst = 1'b0; ack1 = 1'b0;
    rd(4'h9, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v1 !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v1, e.val); end
    rd(4'hA, v, oe, v1);
    e = exp_q.pop_front(); checks++; if (v1 !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, v1, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, req1} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, req1, e.val); end
    e = exp_q.pop_front(); checks++; if ({7'b0, oe1} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, oe1, e.val); end
  endtask

  initial begin
    test_reset;
    test_edge;
    test_nest;
    test_eoi;
    test_mask;
    test_w1c_race;
    test_spurious;
    test_level_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
